// File: rtl/password_verifier_pkg.sv
// Shared state encoding, default widths and counter sizing helper for the
// password verifier slice.
package password_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ENTER  = 2'd0;
    localparam state_t RESULT = 2'd1;
    localparam state_t LOCKED = 2'd2;

    // Bits needed to hold values 0..max_value; never narrower than one bit.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/password_verifier_lockout_timer.sv
// Lockout down-counter: loads LOCK_CYCLES, counts down to zero and flags the
// final counted cycle so the owner can leave the locked state on time.
module lockout_timer
    import password_pkg::*;
#(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int CW = cnt_width(LOCK_CYCLES);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = CW'(LOCK_CYCLES);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // A count of one is the last locked cycle.
    assign expired = (cnt_reg == CW'(1)) && !load;

endmodule

// File: rtl/password_verifier.sv
// Byte-serial password checker: constant-time comparison against storage,
// registered grant/deny strobe and consecutive-failure lockout.
module password_verifier
    import password_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int PW_LEN      = 4,
    parameter int BASE_ADDR   = 0,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          abort,
    output logic [ADDR_W-1:0]             read_addr,
    input  logic [DATA_W-1:0]             read_data,
    output logic                          done,
    output logic                          granted,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

    localparam int IDX_W = cnt_width(PW_LEN - 1);
    localparam int FW    = $clog2(MAX_FAIL + 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             mismatch_reg, mismatch_next;
    logic [FW-1:0]    fail_count_reg, fail_count_next;
    logic             done_reg, done_next;
    logic             granted_reg, granted_next;
    logic             timer_load;
    logic             timer_expired;

    logic [DATA_W-1:0] diff_bits;
    logic              byte_mismatch;

    // Bitwise difference reduced in one step, so every byte costs the same
    // regardless of where it differs.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_diff
            assign diff_bits[gi] = in_data[gi] ^ read_data[gi];
        end
    endgenerate

    assign byte_mismatch = |diff_bits;

    assign read_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_reg);
    assign in_ready   = (state_reg == ENTER);
    assign locked     = (state_reg == LOCKED);
    assign done       = done_reg;
    assign granted    = granted_reg;
    assign fail_count = fail_count_reg;

    lockout_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lockout_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .expired (timer_expired)
    );

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        mismatch_next   = mismatch_reg;
        fail_count_next = fail_count_reg;
        done_next       = 1'b0;
        granted_next    = 1'b0;
        timer_load      = 1'b0;

        case (state_reg)
            ENTER: begin
                if (abort) begin
                    idx_next      = '0;
                    mismatch_next = 1'b0;
                end else if (in_valid) begin
                    mismatch_next = mismatch_reg | byte_mismatch;
                    if (idx_reg == IDX_W'(PW_LEN - 1)) begin
                        idx_next     = '0;
                        state_next   = RESULT;
                        // Result is registered so it appears during RESULT.
                        done_next    = 1'b1;
                        granted_next = ~(mismatch_reg | byte_mismatch);
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end

            RESULT: begin
                mismatch_next = 1'b0;
                state_next    = ENTER;
                if (!mismatch_reg) begin
                    fail_count_next = '0;
                end else if (int'(fail_count_reg) + 1 < MAX_FAIL) begin
                    fail_count_next = fail_count_reg + 1'b1;
                end else begin
                    fail_count_next = FW'(MAX_FAIL);
                    timer_load      = 1'b1;
                    state_next      = LOCKED;
                end
            end

            LOCKED: begin
                if (timer_expired) begin
                    fail_count_next = '0;
                    state_next      = ENTER;
                end
            end

            default: begin
                state_next    = ENTER;
                idx_next      = '0;
                mismatch_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ENTER;
            idx_reg        <= '0;
            mismatch_reg   <= 1'b0;
            fail_count_reg <= '0;
            done_reg       <= 1'b0;
            granted_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            mismatch_reg   <= mismatch_next;
            fail_count_reg <= fail_count_next;
            done_reg       <= done_next;
            granted_reg    <= granted_next;
        end
    end

endmodule

// File: tb/tb_password_verifier.sv
// Directed bench for password_verifier with a small combinational storage
// model holding the password 31 32 33 34 at addresses 0..3.
module tb_password_verifier;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       abort;
    logic [3:0] read_addr;
    logic [7:0] read_data;
    logic       done;
    logic       granted;
    logic       locked;
    logic [1:0] fail_count;

    logic [7:0] mem [16];

    int n_cmp;
    int n_bad;

    password_verifier dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .abort      (abort),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .done       (done),
        .granted    (granted),
        .locked     (locked),
        .fail_count (fail_count)
    );

    assign read_data = mem[read_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic enter_pw(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int exp_grant, input int exp_fail);
        logic [7:0] bytes [4];
        bytes = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = bytes[i];
            check("read_addr", 32'(read_addr), i);
            check("in_ready", 32'(in_ready), 1);
            check("early_done", 32'(done), 0);
            step();
        end
        in_valid = 1'b0;
        check("done", 32'(done), 1);
        check("granted", 32'(granted), exp_grant);
        $display("entry %02h %02h %02h %02h -> done=%0d granted=%0d",
                 b0, b1, b2, b3, done, granted);
        step();
        check("done_low", 32'(done), 0);
        check("granted_low", 32'(granted), 0);
        check("fail_count", 32'(fail_count), exp_fail);
    endtask

    initial begin
        int n;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        abort    = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        mem[0] = 8'h31;
        mem[1] = 8'h32;
        mem[2] = 8'h33;
        mem[3] = 8'h34;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_done", 32'(done), 0);
        check("rst_granted", 32'(granted), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_fail_count", 32'(fail_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_read_addr", 32'(read_addr), 0);

        // Correct entry, then a wrong one that must still take all four bytes.
        enter_pw(8'h31, 8'h32, 8'h33, 8'h34, 1, 0);
        enter_pw(8'h31, 8'h00, 8'h33, 8'h34, 0, 1);

        // Two more denials reach the limit and lock for 16 cycles.
        enter_pw(8'h00, 8'h32, 8'h33, 8'h34, 0, 2);
        check("pre_lock_locked", 32'(locked), 0);
        in_valid = 1'b1;
        in_data  = 8'h31;
        check("first_lock_byte_addr", 32'(read_addr), 0);
        in_valid = 1'b0;
        enter_pw(8'h31, 8'h32, 8'h33, 8'h00, 0, 3);
        check("lock_entered", 32'(locked), 1);
        n = 0;
        in_valid = 1'b1;
        in_data  = 8'h31;
        while (locked && n < 40) begin
            n++;
            check("lock_in_ready", 32'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        $display("lockout lasted %0d cycles", n);
        check("lock_cycles", n, 16);
        check("unlock_in_ready", 32'(in_ready), 1);
        check("unlock_fail_count", 32'(fail_count), 0);
        check("unlock_read_addr", 32'(read_addr), 0);

        // Two denials then a grant clears the count without locking.
        enter_pw(8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        enter_pw(8'h31, 8'h32, 8'h34, 8'h34, 0, 2);
        enter_pw(8'h31, 8'h32, 8'h33, 8'h34, 1, 0);
        check("no_lock", 32'(locked), 0);

        // Abort discards a bad partial entry and does not count a failure.
        enter_pw(8'h31, 8'h32, 8'h33, 8'h35, 0, 1);
        send_byte(8'h31);
        send_byte(8'h00);
        check("partial_addr", 32'(read_addr), 2);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        $display("abort issued at idx 2 -> read_addr=%0d fail_count=%0d", read_addr, fail_count);
        check("abort_no_done", 32'(done), 0);
        check("abort_addr", 32'(read_addr), 0);
        check("abort_fail_count", 32'(fail_count), 1);
        step();
        check("abort_no_done_late", 32'(done), 0);
        enter_pw(8'h31, 8'h32, 8'h33, 8'h34, 1, 0);

        // Reset in the middle of a lockout clears it.
        enter_pw(8'h01, 8'h02, 8'h03, 8'h04, 0, 1);
        enter_pw(8'h01, 8'h02, 8'h03, 8'h04, 0, 2);
        enter_pw(8'h01, 8'h02, 8'h03, 8'h04, 0, 3);
        repeat (4) step();
        check("lock_cycle5_locked", 32'(locked), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("reset during lockout -> locked=%0d fail_count=%0d in_ready=%0d",
                 locked, fail_count, in_ready);
        check("rst_lock_locked", 32'(locked), 0);
        check("rst_lock_fail_count", 32'(fail_count), 0);
        check("rst_lock_in_ready", 32'(in_ready), 1);
        check("rst_lock_done", 32'(done), 0);
        enter_pw(8'h31, 8'h32, 8'h33, 8'h34, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
